// File: rtl/riscv_mem_pkg.sv
// Shared types for the data-memory responder: FSM states, request record and bus widths.
package riscv_mem_pkg;

    localparam int BE_W   = 4;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef struct packed {
        logic              we;
        logic [31:0]       addr;
        logic [WORD_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } req_t;

endpackage

// File: rtl/dmem_byte_array.sv
// Word-organised storage with a byte-enabled write port and a registered read port.
module dmem_byte_array
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     idx,
    input  logic [BE_W-1:0]   be,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_d;
    logic [WORD_W-1:0] rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[idx];
        end
    end

    // Storage is deliberately not reset; only enabled lanes are updated.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES, accesses RAM, responds.
module riscv_dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    state_e      state_d, state_q;
    logic [3:0]  cnt_d, cnt_q;
    req_t        req_d, req_q;
    logic        err_d, err_q;

    logic [32:0]       offset;
    logic              addr_err;
    logic              ram_we;
    logic              ram_re;
    logic [AW-1:0]     ram_idx;
    logic [WORD_W-1:0] ram_rdata;

    // Bit 32 of the 33-bit difference is the borrow, i.e. the address lies below BASE_ADDR.
    assign offset   = {1'b0, req_addr} - {1'b0, BASE_ADDR};
    assign addr_err = (req_addr[1:0] != 2'b00) || offset[32] || ({1'b0, offset[31:0]} >= SPAN);
    assign ram_idx  = AW'((req_q.addr - BASE_ADDR) >> 2);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        err_d   = err_q;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d   = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
                    err_d   = addr_err;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                ram_we  = req_q.we && !err_q;
                ram_re  = !req_q.we && !err_q;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            err_q   <= err_d;
        end
    end

    dmem_byte_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .idx  (ram_idx),
        .be   (req_q.be),
        .wdata(req_q.wdata),
        .rdata(ram_rdata)
    );

    // Response fields are gated by state so they collapse to zero the edge the handshake completes.
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !err_q && !req_q.we) ? ram_rdata : '0;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench for riscv_dmem_responder: one instance with two wait states, one with none.
module tb_riscv_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_a, req_valid_z;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_ready;

    logic        req_ready_a, rsp_valid_a, rsp_err_a;
    logic [31:0] rsp_rdata_a;
    logic        req_ready_z, rsp_valid_z, rsp_err_z;
    logic [31:0] rsp_rdata_z;

    int tests    = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
    );

    riscv_dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut_zero (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_z), .req_ready(req_ready_z),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z)
    );

    // Every comparison in the bench funnels through here so the counts stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction on the chosen instance (sel=1 picks the zero-wait one) with rsp_ready high.
    // lat counts edges from the accepting edge (inclusive) to the edge that raises rsp_valid.
    task automatic applyStimulus(input bit sel, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 output logic [31:0] rdata, output logic err, output int lat);
        int n;
        @(negedge clk);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        if (sel) req_valid_z = 1'b1;
        else     req_valid_a = 1'b1;
        n = 0;
        while ((sel ? req_ready_z : req_ready_a) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) checkOutput("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid_a = 1'b0;
        req_valid_z = 1'b0;
        lat = 1;
        while ((sel ? rsp_valid_z : rsp_valid_a) !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) checkOutput("rsp_timeout", 32'd0, 32'd1);
        rdata = sel ? rsp_rdata_z : rsp_rdata_a;
        err   = sel ? rsp_err_z : rsp_err_a;
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt;
        int          n;
        bit          saw_valid;

        rst_n       = 1'b0;
        rsp_ready   = 1'b1;
        req_valid_a = 1'b0;
        req_valid_z = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_be      = '0;

        // Reset held for two edges, then released.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata_a, 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err_a), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(req_ready_a), 32'd1);
        checkOutput("rst_req_ready_z", 32'(req_ready_z), 32'd1);

        // Full-word store then load, with latency on both instances.
        applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lt);
        checkOutput("st_err", 32'(er), 32'd0);
        checkOutput("st_rdata", rd, 32'd0);
        checkOutput("st_lat", 32'(lt), 32'd4);
        applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lt);
        checkOutput("ld_rdata", rd, 32'hDEADBEEF);
        checkOutput("ld_err", 32'(er), 32'd0);
        checkOutput("ld_lat", 32'(lt), 32'd4);
        applyStimulus(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lt);
        checkOutput("z_st_lat", 32'(lt), 32'd2);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lt);
        checkOutput("z_ld_rdata", rd, 32'hDEADBEEF);
        checkOutput("z_ld_lat", 32'(lt), 32'd2);

        // Byte-lane stores and an all-lanes-disabled store.
        applyStimulus(1'b0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lt);
        applyStimulus(1'b0, 1'b1, 32'h10, 32'h11000000, 4'b1000, rd, er, lt);
        applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lt);
        checkOutput("lane_rdata", rd, 32'h11ADBEAA);
        applyStimulus(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lt);
        checkOutput("be0_err", 32'(er), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lt);
        checkOutput("be0_rdata", rd, 32'h11ADBEAA);

        // Error cases plus the last legal word.
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h12345678, 4'hF, rd, er, lt);
        applyStimulus(1'b0, 1'b1, 32'h3FC, 32'hA5A55A5A, 4'hF, rd, er, lt);
        checkOutput("top_st_err", 32'(er), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h12, 32'h0, 4'hF, rd, er, lt);
        checkOutput("mis_err", 32'(er), 32'd1);
        checkOutput("mis_rdata", rd, 32'd0);
        applyStimulus(1'b0, 1'b1, 32'h400, 32'h5, 4'hF, rd, er, lt);
        checkOutput("oor_err", 32'(er), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, lt);
        checkOutput("oor_w0_rdata", rd, 32'h12345678);
        checkOutput("oor_w0_err", 32'(er), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h3FC, 32'h0, 4'hF, rd, er, lt);
        checkOutput("top_ld_rdata", rd, 32'hA5A55A5A);

        // Back-pressure: response held while a second request waits with req_valid high.
        @(negedge clk);
        rsp_ready   = 1'b0;
        req_we      = 1'b0;
        req_addr    = 32'h10;
        req_valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_addr = 32'h3FC;
        n = 0;
        while (rsp_valid_a !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) checkOutput("stall_timeout", 32'd0, 32'd1);
        repeat (5) begin
            checkOutput("stall_valid", 32'(rsp_valid_a), 32'd1);
            checkOutput("stall_rdata", rsp_rdata_a, 32'h11ADBEAA);
            checkOutput("stall_err", 32'(rsp_err_a), 32'd0);
            checkOutput("stall_ready", 32'(req_ready_a), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("hs_valid", 32'(rsp_valid_a), 32'd0);
        checkOutput("hs_rdata", rsp_rdata_a, 32'd0);
        checkOutput("hs_ready", 32'(req_ready_a), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid_a = 1'b0;
        checkOutput("second_accepted", 32'(req_ready_a), 32'd0);
        n = 0;
        while (rsp_valid_a !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) checkOutput("second_timeout", 32'd0, 32'd1);
        checkOutput("second_rdata", rsp_rdata_a, 32'hA5A55A5A);
        @(posedge clk);

        // Reset while a store sits in its wait states.
        applyStimulus(1'b0, 1'b1, 32'h20, 32'h0BADC0DE, 4'hF, rd, er, lt);
        @(negedge clk);
        req_we      = 1'b1;
        req_addr    = 32'h20;
        req_wdata   = 32'hCAFEF00D;
        req_be      = 4'hF;
        req_valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_a = 1'b0;
        rst_n       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("mid_rst_ready", 32'(req_ready_a), 32'd1);
        saw_valid = 1'b0;
        repeat (6) begin
            if (rsp_valid_a === 1'b1) saw_valid = 1'b1;
            @(negedge clk);
        end
        checkOutput("mid_rst_no_rsp", 32'(saw_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lt);
        checkOutput("mid_rst_rdata", rd, 32'h0BADC0DE);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
